// File: rtl/code_counter.sv
// Dual event counter: Output0 counts every enabled Slt=0 cycle, Output1 counts once per DIV enabled Slt=1 cycles.
// Optional saturation of both counters is enabled with `define CODE_COUNTER_SATURATE_EN.
module code_counter #(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_slt,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_output0,
  output logic [WIDTH-1:0] o_output1
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [WIDTH-1:0] r_cnt0;
  logic [WIDTH-1:0] r_cnt1;
  logic [PW-1:0]    r_pre;

  logic [WIDTH-1:0] w_cnt0_inc;
  logic [WIDTH-1:0] w_cnt1_inc;
  logic             w_pre_wrap;

  // Incremented values; with saturation the counters stick at all-ones.
  always_comb begin
`ifdef CODE_COUNTER_SATURATE_EN
    w_cnt0_inc = (&r_cnt0) ? r_cnt0 : r_cnt0 + WIDTH'(1);
    w_cnt1_inc = (&r_cnt1) ? r_cnt1 : r_cnt1 + WIDTH'(1);
`else
    w_cnt0_inc = r_cnt0 + WIDTH'(1);
    w_cnt1_inc = r_cnt1 + WIDTH'(1);
`endif
    w_pre_wrap = (r_pre == PRE_MAX);
  end

  // The prescaler keeps its partial progress across Slt toggles and only clears on reset or wrap.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_pre  <= '0;
    end else if (i_en) begin
      if (!i_slt) begin
        r_cnt0 <= w_cnt0_inc;
      end else if (w_pre_wrap) begin
        r_pre  <= '0;
        r_cnt1 <= w_cnt1_inc;
      end else begin
        r_pre  <= r_pre + PW'(1);
      end
    end
  end

  assign o_output0 = r_cnt0;
  assign o_output1 = r_cnt1;

endmodule

// File: tb/tb_code_counter.sv
// Self-checking bench for code_counter: directed plan plus random stimulus against an arithmetic model.
// Drives a 64-bit/DIV=4 instance and a 4-bit/DIV=2 instance with identical stimulus.
module tb_code_counter;

  logic        clk;
  logic        resetN;
  logic        slt;
  logic        en;
  logic [63:0] out0;
  logic [63:0] out1;
  logic [3:0]  smallOut0;
  logic [3:0]  smallOut1;

  int testsRun;
  int testsFailed;

  // Model state: number of qualifying edges of each kind since the last reset.
  longint unsigned n0;
  longint unsigned q1;

  code_counter #(.WIDTH(64), .DIV(4)) dut (
    .i_clk(clk), .i_reset_n(resetN), .i_slt(slt), .i_en(en),
    .o_output0(out0), .o_output1(out1)
  );

  code_counter #(.WIDTH(4), .DIV(2)) dutSmall (
    .i_clk(clk), .i_reset_n(resetN), .i_slt(slt), .i_en(en),
    .o_output0(smallOut0), .o_output1(smallOut1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] smallVal(input longint unsigned v);
`ifdef CODE_COUNTER_SATURATE_EN
    return (v > 15) ? 64'd15 : 64'(v);
`else
    return 64'(v % 16);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock edge with the given inputs, then compare both instances against the model.
  task automatic applyStimulus(input logic r, input logic e, input logic s, input string tag);
    resetN = r;
    en     = e;
    slt    = s;
    @(posedge clk);
    if (!r) begin
      n0 = 0;
      q1 = 0;
    end else if (e) begin
      if (!s) n0++;
      else    q1++;
    end
    #1;
    checkOutput({tag, "_out0"}, out0, 64'(n0));
    checkOutput({tag, "_out1"}, out1, 64'(q1 / 4));
    checkOutput({tag, "_small0"}, {60'd0, smallOut0}, smallVal(n0));
    checkOutput({tag, "_small1"}, {60'd0, smallOut1}, smallVal(q1 / 2));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    n0 = 0;
    q1 = 0;
    resetN = 1'b0;
    en     = 1'b1;
    slt    = 1'b1;

    // Reset held for two edges while enabled.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, "reset");
    checkOutput("plan_reset_out1", out1, 64'd0);

    // Direct count.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, "direct");
    checkOutput("plan_direct_out0", out0, 64'd10);
    checkOutput("plan_direct_out1", out1, 64'd0);

    // Prescaled count from reset.
    applyStimulus(1'b0, 1'b1, 1'b1, "rst");
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, "presc");
      checkOutput("plan_presc_out1", out1, (i < 4) ? 64'd0 : (i < 8) ? 64'd1 : 64'd2);
    end
    checkOutput("plan_presc_out0", out0, 64'd0);

    // Prescaler retention across Slt toggles and enable hold.
    applyStimulus(1'b0, 1'b1, 1'b1, "rst");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, "retain_a");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, "retain_b");
    checkOutput("plan_retain_out0", out0, 64'd5);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, "hold");
    checkOutput("plan_hold_out0", out0, 64'd5);
    checkOutput("plan_hold_out1", out1, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, "retain_c");
    checkOutput("plan_retain_out1", out1, 64'd1);

    // Mid-count reset discards the partial prescale.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, "mid_a");
    applyStimulus(1'b0, 1'b1, 1'b1, "mid_rst");
    checkOutput("plan_mid_rst_out1", out1, 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, "mid_b");
    checkOutput("plan_mid_3_out1", out1, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, "mid_c");
    checkOutput("plan_mid_4_out1", out1, 64'd1);

    // Wrap or saturate on the 4-bit instance.
    applyStimulus(1'b0, 1'b1, 1'b0, "rst");
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b0, "wrap");
`ifdef CODE_COUNTER_SATURATE_EN
    checkOutput("plan_sat_small0", {60'd0, smallOut0}, 64'd15);
`else
    checkOutput("plan_wrap_small0", {60'd0, smallOut0}, 64'd1);
`endif

    // Random stimulus with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
